// File: rtl/cpu_ctrl_pkg.sv
// Shared types and opcode constants for the CPU instruction-sequencing control path.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_OP = 3'd1,
        FETCH_A  = 3'd2,
        FETCH_B  = 3'd3,
        EXEC     = 3'd4,
        WAIT     = 3'd5,
        HALT     = 3'd6,
        PAUSE    = 3'd7
    } state_t;

    typedef logic [1:0] opnd_cnt_t;

    localparam opnd_cnt_t CNT_0 = 2'd0;
    localparam opnd_cnt_t CNT_1 = 2'd1;
    localparam opnd_cnt_t CNT_2 = 2'd2;

    localparam logic [4:0] OPC_HLT      = 5'b11111;
    localparam logic [4:0] OPC_2OP_LO   = 5'b00100;
    localparam logic [4:0] OPC_2OP_HI   = 5'b01100;
    localparam logic [4:0] OPC_1OP_LO   = 5'b01101;
    localparam logic [4:0] OPC_1OP_HI   = 5'b10011;
    localparam logic [4:0] OPC_1OP_EXCL = 5'b01110;

endpackage

// File: rtl/opnd_count_decode.sv
// Combinational opcode class decode: number of operand bytes and the HLT flag.
// Also used by the operand register block to qualify its loads.
module opnd_count_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output opnd_cnt_t        count,
    output logic             is_hlt
);

    always_comb begin
        count = CNT_0;
        if (opcode >= OPC_W'(OPC_2OP_LO) && opcode <= OPC_W'(OPC_2OP_HI)) begin
            count = CNT_2;
        end else if (opcode >= OPC_W'(OPC_1OP_LO) && opcode <= OPC_W'(OPC_1OP_HI) &&
                     opcode != OPC_W'(OPC_1OP_EXCL)) begin
            count = CNT_1;
        end
    end

    assign is_hlt = (opcode == OPC_W'(OPC_HLT));

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Instruction sequencer: fetches opcode and operand bytes, strobes operand loads and execute,
// and maintains the PC. Defining SINGLE_STEP_EN adds a step input and a PAUSE state.
module operand_fetch_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int OPC_W  = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] opnd_data,
    output logic              opnd_load,
    output logic              exec_start,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
`ifdef SINGLE_STEP_EN
    ,
    input  logic              step
`endif
);

    state_t           state;
    state_t           state_next;
    logic             byte_ack;
    logic [OPC_W-1:0] dec_opcode;
    opnd_cnt_t        dec_count;
    logic             dec_hlt;

    // While the opcode byte is arriving the register is stale, so decode the bus directly.
    assign dec_opcode = (state == FETCH_OP) ? mem_data[OPC_W-1:0] : opcode;

    opnd_count_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode (dec_opcode),
        .count  (dec_count),
        .is_hlt (dec_hlt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        exec_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH_OP;
            end
            FETCH_OP: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    if (dec_hlt)                state_next = HALT;
                    else if (dec_count == CNT_0) state_next = EXEC;
                    else                        state_next = FETCH_A;
                end
            end
            FETCH_A: begin
                mem_rd = 1'b1;
                if (mem_ack) state_next = (dec_count == CNT_2) ? FETCH_B : EXEC;
            end
            FETCH_B: begin
                mem_rd = 1'b1;
                if (mem_ack) state_next = EXEC;
            end
            EXEC: begin
                // Hold off one cycle if the final operand strobe is still on the bus.
                if (!opnd_load) begin
                    exec_start = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
`ifdef SINGLE_STEP_EN
                if (exec_done) state_next = PAUSE;
`else
                if (exec_done) state_next = FETCH_OP;
`endif
            end
            HALT: begin
                state_next = HALT;
            end
`ifdef SINGLE_STEP_EN
            PAUSE: begin
                if (step) state_next = FETCH_OP;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign byte_ack = mem_rd && mem_ack;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc        <= '0;
            opcode    <= '0;
            opnd_data <= '0;
            opnd_load <= 1'b0;
        end else begin
            opnd_load <= byte_ack && (state == FETCH_A || state == FETCH_B);
            if (byte_ack) begin
                pc <= pc + ADDR_W'(1);
                if (state == FETCH_OP) begin
                    opcode <= mem_data[OPC_W-1:0];
                end else begin
                    opnd_data <= mem_data;
                end
            end else if (state == WAIT && exec_done && branch_taken) begin
                pc <= branch_target;
            end
        end
    end

    assign mem_addr = pc;
    assign busy     = !(state == IDLE || state == HALT || state == PAUSE);
    assign halted   = (state == HALT);

endmodule
